quad_decoder_counter: RTL and testbench

//  Decodes a 2-phase quadrature encoder input (A/B) into up/down step events.

---
 rtl/quad_decoder_counter.sv | 108 ++++++++++
 tb/tb_quad_decoder_counter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder_counter.sv
// Quadrature (A/B) decoder in 4x mode driving a loadable up/down position counter.
// Pins are synchronised; illegal two-bit transitions raise a sticky error.
module quad_decoder_counter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  // Tracks how far real pin samples have travelled down the synchroniser.
  logic [SYNC_STAGES-1:0] fill_q;
  logic [1:0]             s, prev_q;
  logic                   primed_q, primed_d;
  logic [WIDTH-1:0]       count_q, count_d;
  logic                   dir_q, dir_d;
  logic                   step_q, step_d;
  logic                   err_q, err_d;
  logic                   up, down, illegal;

  assign s = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      fill_q   <= '0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_in};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_in};
      fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_comb begin
    up      = 1'b0;
    down    = 1'b0;
    illegal = 1'b0;
    if (primed_q) begin
      // Gray order 00->10->11->01->00: successor is {~B, A}, predecessor is {B, ~A}.
      up      = (s == {~prev_q[0], prev_q[1]});
      down    = (s == {prev_q[0], ~prev_q[1]});
      illegal = (s == ~prev_q);
    end

    // Priming waits until the synchroniser holds real pin samples, so the reset
    // zeros in the chain are never mistaken for a pin transition.
    primed_d = primed_q | fill_q[SYNC_STAGES-1];
    step_d   = up | down;

    dir_d = dir_q;
    if (up) begin
      dir_d = 1'b1;
    end else if (down) begin
      dir_d = 1'b0;
    end

    count_d = count_q;
    if (load) begin
      count_d = data;
    end else if (up) begin
      count_d = count_q + WIDTH'(1);
    end else if (down) begin
      count_d = count_q - WIDTH'(1);
    end

    err_d = err_q;
    if (illegal) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q   <= 2'b00;
      primed_q <= 1'b0;
      count_q  <= '0;
      dir_q    <= 1'b1;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      prev_q   <= s;
      primed_q <= primed_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      err_q    <= err_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign step  = step_q;
  assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Randomised and directed checks of quad_decoder_counter against a pin-history model.
module tb_quad_decoder_counter;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned SYNC_STAGES = 2;

  logic             clk;
  logic             rst;
  logic             a, b;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             clr_err;
  logic [WIDTH-1:0] count;
  logic             dir, step, err;

  int n_cmp = 0;
  int n_bad = 0;
  int step_cnt = 0;
  int gi = 0;
  logic [1:0] gray [4];

  quad_decoder_counter #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .a_in   (a),
    .b_in   (b),
    .load   (load),
    .data   (data),
    .clr_err(clr_err),
    .count  (count),
    .dir    (dir),
    .step   (step),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [1:0]       hist [$];
  logic [WIDTH-1:0] m_count;
  logic             m_dir, m_step, m_err;

  function automatic int gray_pos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // The pins sampled SYNC_STAGES edges ago are compared with the sample one edge
  // earlier; decoding starts once both of those samples postdate reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist.delete();
      m_count = '0;
      m_dir   = 1'b1;
      m_step  = 1'b0;
      m_err   = 1'b0;
    end else begin
      int d;
      logic ill;
      hist.push_back({a, b});
      if (hist.size() > SYNC_STAGES + 2) void'(hist.pop_front());
      m_step = 1'b0;
      ill    = 1'b0;
      if (hist.size() == SYNC_STAGES + 2) begin
        d = (gray_pos(hist[1]) - gray_pos(hist[0]) + 4) % 4;
        if (d == 1) begin
          m_step = 1'b1; m_dir = 1'b1; m_count = m_count + 1'b1;
        end else if (d == 3) begin
          m_step = 1'b1; m_dir = 1'b0; m_count = m_count - 1'b1;
        end else if (d == 2) begin
          ill = 1'b1;
        end
      end
      if (load) m_count = data;
      if (ill) m_err = 1'b1;
      else if (clr_err) m_err = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_count", 32'(count), 32'(m_count));
    check("model_dir", 32'(dir), 32'(m_dir));
    check("model_step", 32'(step), 32'(m_step));
    check("model_err", 32'(err), 32'(m_err));
    if (step === 1'b1) step_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic move(input int delta);
    gi = (gi + delta) % 4;
    {a, b} = gray[gi];
  endtask

  initial begin
    int s0;
    gray[0] = 2'b00; gray[1] = 2'b10; gray[2] = 2'b11; gray[3] = 2'b01;
    rst = 1'b0; load = 1'b0; data = '0; clr_err = 1'b0;
    gi = 2; {a, b} = 2'b11;

    // 1: pins high through reset, no counting or error afterwards
    clks(3);
    check("reset_count", 32'(count), 32'h0);
    check("reset_dir", 32'(dir), 32'h1);
    check("reset_err", 32'(err), 32'h0);
    s0 = step_cnt;
    rst = 1'b1;
    clks(10);
    check("t1_count", 32'(count), 32'h0);
    check("t1_err", 32'(err), 32'h0);
    check("t1_nostep", 32'(step_cnt - s0), 32'h0);

    // 2: eight up edges from 00
    rst = 1'b0; gi = 0; {a, b} = 2'b00;
    clks(2);
    rst = 1'b1;
    clks(6);
    s0 = step_cnt;
    move(1);
    clks(2);
    check("t2_lag2", 32'(step), 32'h0);
    clks(1);
    check("t2_lag3", 32'(step), 32'h1);
    clks(1);
    for (int i = 0; i < 7; i++) begin
      move(1);
      clks(4);
    end
    clks(2);
    check("t2_count", 32'(count), 32'h8);
    check("t2_dir", 32'(dir), 32'h1);
    check("t2_steps", 32'(step_cnt - s0), 32'h8);

    // 3: load FF then wrap up, then down
    load = 1'b1; data = 8'hFF;
    clks(1);
    load = 1'b0;
    check("t3_load", 32'(count), 32'hFF);
    move(1); clks(4);
    check("t3_up0", 32'(count), 32'h00);
    move(1); clks(4);
    check("t3_up1", 32'(count), 32'h01);
    move(3); clks(4);
    check("t3_dn0", 32'(count), 32'h00);
    move(3); clks(4);
    check("t3_dn1", 32'(count), 32'hFF);
    move(3); clks(4);
    check("t3_dn2", 32'(count), 32'hFE);
    check("t3_dir", 32'(dir), 32'h0);

    // 4: illegal jump, clear, clear racing a new fault
    move(2); clks(4);
    check("t4_err", 32'(err), 32'h1);
    check("t4_count", 32'(count), 32'hFE);
    clr_err = 1'b1; clks(1); clr_err = 1'b0;
    check("t4_clr", 32'(err), 32'h0);
    move(2); clks(2);
    clr_err = 1'b1; clks(1); clr_err = 1'b0;
    check("t4_set_wins", 32'(err), 32'h1);
    clks(1);
    check("t4_sticky", 32'(err), 32'h1);

    // 5: load and up edge hit decode together
    move(1); clks(2);
    load = 1'b1; data = 8'h40; clks(1); load = 1'b0;
    check("t5_count", 32'(count), 32'h40);
    check("t5_step", 32'(step), 32'h1);
    check("t5_dir", 32'(dir), 32'h1);
    clks(2);

    // 6: async reset at count 5, then count resumes from 0
    load = 1'b1; data = 8'h03; clks(1); load = 1'b0;
    move(1); clks(4);
    move(1); clks(4);
    check("t6_pre", 32'(count), 32'h5);
    @(posedge clk); #2 rst = 1'b0; #1;
    check("t6_count", 32'(count), 32'h0);
    check("t6_dir", 32'(dir), 32'h1);
    check("t6_err", 32'(err), 32'h0);
    clks(2);
    rst = 1'b1;
    clks(6);
    move(1); clks(4);
    check("t6_resume", 32'(count), 32'h1);

    // randomised traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      load    = ($urandom_range(0, 19) == 0);
      data    = WIDTH'($urandom);
      clr_err = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 19);
      if (r < 4) move(1);
      else if (r < 7) move(3);
      else if (r == 7) move(2);
      clks(1);
    end
    load = 1'b0; clr_err = 1'b0;
    clks(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
